// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH = 1024;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } dmem_resp_t;

  // Misaligned or beyond the last word of a depth-word memory.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin grant; the port granted last loses the next tie.
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic       enable,
  input  logic       accept,
  output logic [1:0] grant
);

  port_t last_grant_q, last_grant_d;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_grant_q == PORT1) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = grant[1] ? PORT1 : PORT0;
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= PORT1;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory,
// returning a registered one-cycle-latency response to the winning port.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH = DMEM_DEPTH,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_write,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic [1:0]  resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  logic [1:0] grant;
  logic       granted;
  logic       err;
  dmem_req_t  req0, req1, sel;

  logic [1:0] resp_valid_q, resp_valid_d;
  dmem_resp_t resp_q, resp_d;

  // Reset suppresses grants so requests held during reset stay pending.
  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .enable    (!reset),
    .accept    (granted),
    .grant     (grant)
  );

  assign req_ready = grant;
  assign granted   = |grant;

  always_comb begin
    req0.write = req_write[0];
    req0.addr  = req_addr0;
    req0.wdata = req_wdata0;
    req1.write = req_write[1];
    req1.addr  = req_addr1;
    req1.wdata = req_wdata1;
    sel        = grant[1] ? req1 : req0;
    err        = granted && addr_bad(sel.addr, DEPTH);

    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    if (granted && !err) begin
      mem_address[IDX_W-1:0] = sel.addr[IDX_W+1:2];
      mem_write_data         = sel.wdata;
      mem_write              = sel.write;
      mem_read               = !sel.write;
    end

    resp_valid_d = grant;
    resp_d.err   = err;
    resp_d.rdata = mem_read ? mem_read_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= '0;
      resp_q       <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_q.err;
  assign resp_rdata = resp_q.rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a per-cycle behavioural model check.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_write, resp_valid;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic        resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] dev_mem [0:1023];
  logic [31:0] mdl_mem [0:1023];

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(1024)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr0      (req_addr0),
    .req_addr1      (req_addr1),
    .req_wdata0     (req_wdata0),
    .req_wdata1     (req_wdata1),
    .resp_valid     (resp_valid),
    .resp_err       (resp_err),
    .resp_rdata     (resp_rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  // Memory device: combinational read, write on posedge.
  assign mem_read_data = mem_read ? dev_mem[mem_address[9:0]] : 32'h0;
  always @(posedge clk) if (mem_write) dev_mem[mem_address[9:0]] <= mem_write_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model, evaluated mid-cycle ----------------
  int          m_last = 1;
  logic [1:0]  m_rv = 2'b00;
  logic        m_err = 1'b0;
  logic [31:0] m_rd = 32'h0;

  always @(negedge clk) begin
    int          g;
    logic [31:0] a, wd;
    logic        w, e;

    check("m.resp_valid", 32'(resp_valid), 32'(m_rv));
    check("m.resp_err",   32'(resp_err),   32'(m_err));
    check("m.resp_rdata", resp_rdata,      m_rd);

    g = -1;
    if (!reset) begin
      if (req_valid == 2'b01)      g = 0;
      else if (req_valid == 2'b10) g = 1;
      else if (req_valid == 2'b11) g = (m_last == 1) ? 0 : 1;
    end
    a  = (g == 1) ? req_addr1 : req_addr0;
    wd = (g == 1) ? req_wdata1 : req_wdata0;
    w  = (g == 1) ? req_write[1] : req_write[0];
    e  = (a % 4 != 0) || (a / 4 >= 1024);

    check("m.req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (g == 0 ? 32'd1 : 32'd2));
    check("m.mem_write", 32'(mem_write), 32'(g >= 0 && w && !e));
    check("m.mem_read",  32'(mem_read),  32'(g >= 0 && !w && !e));
    check("m.mem_address",    mem_address,    (g >= 0 && !e) ? a / 4 : 32'd0);
    check("m.mem_write_data", mem_write_data, (g >= 0 && !e) ? wd : 32'd0);

    if (reset) begin
      m_rv = 2'b00; m_err = 1'b0; m_rd = 32'h0; m_last = 1;
    end else if (g >= 0) begin
      m_rv  = (g == 0) ? 2'b01 : 2'b10;
      m_err = e;
      m_rd  = (!w && !e) ? mdl_mem[a[11:2]] : 32'h0;
      if (w && !e) mdl_mem[a[11:2]] = wd;
      m_last = g;
    end else begin
      m_rv = 2'b00; m_err = 1'b0; m_rd = 32'h0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    req_valid = 2'b00;
    req_write = 2'b00;
  endtask

  task automatic drive(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid[p] = 1'b1;
    req_write[p] = w;
    if (p == 0) begin req_addr0 = a; req_wdata0 = d; end
    else        begin req_addr1 = a; req_wdata1 = d; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] = (i < 8) ? 32'(i) : 32'h0;
      mdl_mem[i] = (i < 8) ? 32'(i) : 32'h0;
    end
    reset = 1'b1;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    idle();
    tick(); tick();
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.req_ready",  32'(req_ready),  32'd0);
    check("rst.resp_rdata", resp_rdata,      32'd0);
    check("rst.mem_write",  32'(mem_write),  32'd0);
    reset = 1'b0;

    // Back-to-back loads of preloaded words 0..7.
    for (int k = 0; k < 8; k++) begin
      drive(0, 1'b0, 32'(k * 4), 32'h0);
      tick();
      check("b2b.resp_valid", 32'(resp_valid), 32'd1);
      check("b2b.resp_rdata", resp_rdata,      32'(k));
    end
    idle();
    tick();
    check("b2b.end_valid", 32'(resp_valid), 32'd0);

    // Store then load at 0x10.
    drive(0, 1'b1, 32'h10, 32'hDEADBEEF);
    #1;
    check("raw.st_addr",  mem_address,      32'd4);
    check("raw.st_write", 32'(mem_write),   32'd1);
    tick();
    check("raw.st_resp",  32'(resp_valid),  32'd1);
    drive(0, 1'b0, 32'h10, 32'h0);
    #1;
    check("raw.ld_addr",  mem_address,      32'd4);
    check("raw.ld_read",  32'(mem_read),    32'd1);
    tick();
    check("raw.ld_resp",  32'(resp_valid),  32'd1);
    check("raw.ld_rdata", resp_rdata,       32'hDEADBEEF);
    check("raw.ld_err",   32'(resp_err),    32'd0);
    idle();
    tick();

    // Both ports continuously valid right after reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr.grant", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    idle();
    tick();

    // Port 1 misaligned and out-of-range loads.
    drive(1, 1'b0, 32'h0000_1002, 32'h0);
    #1;
    check("err1.mem_read",  32'(mem_read),  32'd0);
    check("err1.mem_write", 32'(mem_write), 32'd0);
    tick();
    check("err1.resp_valid", 32'(resp_valid), 32'd2);
    check("err1.resp_err",   32'(resp_err),   32'd1);
    check("err1.resp_rdata", resp_rdata,      32'd0);
    drive(1, 1'b0, 32'h0000_1000, 32'h0);
    #1;
    check("err2.mem_read",  32'(mem_read),  32'd0);
    tick();
    check("err2.resp_valid", 32'(resp_valid), 32'd2);
    check("err2.resp_err",   32'(resp_err),   32'd1);
    idle();
    tick();
    check("err.cleared", 32'(resp_err), 32'd0);

    // Last legal word across ports.
    drive(0, 1'b1, 32'hFFC, 32'h1);
    tick();
    idle();
    drive(1, 1'b0, 32'hFFC, 32'h0);
    #1;
    check("top.mem_address", mem_address, 32'd1023);
    tick();
    check("top.resp_valid", 32'(resp_valid), 32'd2);
    check("top.resp_rdata", resp_rdata,      32'h1);
    check("top.resp_err",   32'(resp_err),   32'd0);
    idle();
    tick();

    // Store held valid across a reset cycle.
    reset = 1'b1;
    drive(0, 1'b1, 32'h20, 32'h55);
    #1;
    check("rs.mem_write", 32'(mem_write), 32'd0);
    check("rs.req_ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rs.no_resp",    32'(resp_valid), 32'd0);
    check("rs.late_ready", 32'(req_ready),  32'd1);
    check("rs.late_write", 32'(mem_write),  32'd1);
    tick();
    check("rs.resp", 32'(resp_valid), 32'd1);
    idle();
    drive(0, 1'b0, 32'h20, 32'h0);
    tick();
    check("rs.readback", resp_rdata, 32'h55);
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
